// File: rtl/frv_masked_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frv_masked_pkg : operation encodings shared by the masked ISE datapath units
// Revision 1.0
// ---------------------------------------------------------------------------
package frv_masked_pkg;

   typedef logic [1:0] msk_op_t;

   localparam msk_op_t MSK_AND  = 2'd0;
   localparam msk_op_t MSK_OR   = 2'd1;
   localparam msk_op_t MSK_XOR  = 2'd2;
   localparam msk_op_t MSK_ANDN = 2'd3;

endpackage
`default_nettype wire

// File: rtl/frv_dom_and_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frv_dom_and_stage : DOM-indep product/cross-term registers (glitch boundary)
// Revision 1.0
// ---------------------------------------------------------------------------
module frv_dom_and_stage #(
   parameter int N = 32
) (
   input  logic         g_clk,
   input  logic         g_rst,
   input  logic         en_i,
   input  logic         lin_i,
   input  logic [N-1:0] xa_i,
   input  logic [N-1:0] ya_i,
   input  logic [N-1:0] xb_i,
   input  logic [N-1:0] yb_i,
   input  logic [N-1:0] z_i,
   output logic [N-1:0] pa_o,
   output logic [N-1:0] pb_o,
   output logic [N-1:0] ca_o,
   output logic [N-1:0] cb_o
);

   logic [N-1:0] pa_d, pb_d, ca_d, cb_d;
   logic [N-1:0] pa_q, pb_q, ca_q, cb_q;

   // Cross-domain products exist only blinded by z and are registered before
   // any recombination; linear (XOR) mode keeps the domains fully separate.
   always_comb begin
      pa_d = lin_i ? (xa_i ^ ya_i) : (xa_i & ya_i);
      pb_d = lin_i ? (xb_i ^ yb_i) : (xb_i & yb_i);
      ca_d = lin_i ? '0 : ((xa_i & yb_i) ^ z_i);
      cb_d = lin_i ? '0 : ((xb_i & ya_i) ^ z_i);
   end

   always_ff @(posedge g_clk or posedge g_rst) begin
      if (g_rst) begin
         pa_q <= '0;
         pb_q <= '0;
         ca_q <= '0;
         cb_q <= '0;
      end else if (en_i) begin
         pa_q <= pa_d;
         pb_q <= pb_d;
         ca_q <= ca_d;
         cb_q <= cb_d;
      end
   end

   assign pa_o = pa_q;
   assign pb_o = pb_q;
   assign ca_o = ca_q;
   assign cb_o = cb_q;

endmodule
`default_nettype wire

// File: rtl/frv_masked_dom_bitwise.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frv_masked_dom_bitwise : two-stage two-share masked AND/OR/XOR/ANDN unit
// Revision 1.0
// ---------------------------------------------------------------------------
module frv_masked_dom_bitwise
   import frv_masked_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         g_clk,
   input  logic         g_rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [N-1:0] ax,
   input  logic [N-1:0] bx,
   input  logic [N-1:0] ay,
   input  logic [N-1:0] by,
   input  logic [N-1:0] z,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] qa,
   output logic [N-1:0] qb
);

   logic           s1_valid_q, s2_valid_q;
   logic [1:0]     s1_op_q;
   logic [N-1:0]   qa_q, qb_q;
   logic [N-1:0]   qa_d, qb_d;
   logic [N-1:0]   ax_pre, ay_pre;
   logic [N-1:0]   pa, pb, ca, cb;
   logic           s2_adv, s1_adv, accept;

   assign s2_adv   = out_ready | ~s2_valid_q;
   assign s1_adv   = s1_valid_q & s2_adv;
   assign in_ready = ~s1_valid_q | s2_adv;
   assign accept   = in_valid & in_ready;

   // Inversions touch domain A only, so the masked value is negated without
   // ever combining the two shares.
   assign ax_pre = (op == MSK_OR) ? ~ax : ax;
   assign ay_pre = ((op == MSK_OR) || (op == MSK_ANDN)) ? ~ay : ay;

   frv_dom_and_stage #(.N(N)) u_s1 (
      .g_clk (g_clk),
      .g_rst (g_rst),
      .en_i  (accept),
      .lin_i (op == MSK_XOR),
      .xa_i  (ax_pre),
      .ya_i  (ay_pre),
      .xb_i  (bx),
      .yb_i  (by),
      .z_i   (z),
      .pa_o  (pa),
      .pb_o  (pb),
      .ca_o  (ca),
      .cb_o  (cb)
   );

   always_comb begin
      qa_d = pa ^ ca ^ {N{s1_op_q == MSK_OR}};
      qb_d = pb ^ cb;
   end

   always_ff @(posedge g_clk or posedge g_rst) begin
      if (g_rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_op_q    <= MSK_AND;
         qa_q       <= '0;
         qb_q       <= '0;
      end else begin
         s1_valid_q <= accept | (s1_valid_q & ~s1_adv);
         if (accept) begin
            s1_op_q <= op;
         end
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
         end
         if (s1_adv) begin
            qa_q <= qa_d;
            qb_q <= qb_d;
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign qa        = qa_q;
   assign qb        = qb_q;

endmodule
`default_nettype wire

// File: tb/tb_frv_masked_dom_bitwise.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_frv_masked_dom_bitwise : directed vector table plus randomised scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_frv_masked_dom_bitwise;

   localparam int N  = 8;
   localparam int NV = 10;
   localparam int NR = 10000;

   typedef struct {
      logic [1:0]   op;
      logic [N-1:0] ax, bx, ay, by, z;
      logic [N-1:0] exp_r;
      logic [N-1:0] exp_qa;
      bit           chk_qa;
   } vec_t;

   logic         g_clk = 1'b0;
   logic         g_rst;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [1:0]   op;
   logic [N-1:0] ax, bx, ay, by, z, qa, qb;

   int n_tests = 0;
   int n_fail  = 0;

   vec_t vecs [NV];
   int   b2b  [4];

   frv_masked_dom_bitwise #(.N(N)) dut (
      .g_clk     (g_clk),
      .g_rst     (g_rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .ax        (ax),
      .bx        (bx),
      .ay        (ay),
      .by        (by),
      .z         (z),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .qa        (qa),
      .qb        (qb)
   );

   always #5 g_clk = ~g_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      op = v.op; ax = v.ax; bx = v.bx; ay = v.ay; by = v.by; z = v.z;
   endtask

   function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
      case (o)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return a & ~b;
      endcase
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] sqa, sqb;
      logic [N-1:0] expq [$];
      int           acc, sent;
      logic         took;

      //            op     ax     bx     ay     by     z      res    qa     chk
      vecs[0] = '{2'd0, 8'h3C, 8'h99, 8'h55, 8'h5A, 8'h6E, 8'h05, 8'h62, 1'b1};
      vecs[1] = '{2'd0, 8'h3C, 8'h99, 8'h55, 8'h5A, 8'h00, 8'h05, 8'h0C, 1'b1};
      vecs[2] = '{2'd1, 8'h3C, 8'h99, 8'h55, 8'h5A, 8'h6E, 8'hAF, 8'h51, 1'b1};
      vecs[3] = '{2'd2, 8'h3C, 8'h99, 8'h55, 8'h5A, 8'h6E, 8'hAA, 8'h69, 1'b1};
      vecs[4] = '{2'd2, 8'h3C, 8'h99, 8'h55, 8'h5A, 8'hFF, 8'hAA, 8'h69, 1'b1};
      vecs[5] = '{2'd3, 8'h3C, 8'h99, 8'h55, 8'h5A, 8'h6E, 8'hA0, 8'h5E, 1'b1};
      vecs[6] = '{2'd0, 8'hF0, 8'h0F, 8'h33, 8'h33, 8'hC4, 8'h00, 8'h00, 1'b0};
      vecs[7] = '{2'd1, 8'hF0, 8'h0F, 8'h33, 8'h33, 8'h17, 8'hFF, 8'h00, 1'b0};
      vecs[8] = '{2'd3, 8'hF0, 8'h0F, 8'h33, 8'h33, 8'h81, 8'hFF, 8'h00, 1'b0};
      vecs[9] = '{2'd2, 8'hF0, 8'h0F, 8'h33, 8'h33, 8'h5D, 8'hFF, 8'h00, 1'b0};
      b2b = '{0, 2, 3, 5};

      g_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; ax = '0; bx = '0; ay = '0; by = '0; z = '0;
      repeat (2) @(posedge g_clk);
      #1 g_rst = 1'b0;
      @(posedge g_clk); #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_qa", qa, 0);
      check("reset_qb", qb, 0);
      check("reset_in_ready", in_ready, 1);

      // Single beats, one at a time
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]); in_valid = 1'b1; out_ready = 1'b1;
         #1 check("tbl_in_ready", in_ready, 1);
         @(posedge g_clk); #1 in_valid = 1'b0;
         check("tbl_not_yet_valid", out_valid, 0);
         @(posedge g_clk); #1;
         check("tbl_out_valid", out_valid, 1);
         check("tbl_result", qa ^ qb, vecs[i].exp_r);
         if (vecs[i].chk_qa) check("tbl_qa_share", qa, vecs[i].exp_qa);
      end

      // Back-to-back AND, OR, XOR, ANDN
      for (int c = 0; c < 6; c++) begin
         if (c < 4) begin drive(vecs[b2b[c]]); in_valid = 1'b1; end
         else in_valid = 1'b0;
         @(posedge g_clk); #1;
         if (c == 0 || c == 5) check("b2b_gap", out_valid, 0);
         else begin
            check("b2b_valid", out_valid, 1);
            check("b2b_result", qa ^ qb, vecs[b2b[c-1]].exp_r);
         end
      end

      // Stall with in_valid held high
      out_ready = 1'b0; acc = 0; sqa = '0; sqb = '0;
      for (int c = 0; c < 5; c++) begin
         drive(vecs[b2b[acc % 4]]); in_valid = 1'b1;
         #1 took = in_ready;
         @(posedge g_clk);
         if (took) acc++;
         #1;
         if (c == 1) begin sqa = qa; sqb = qb; end
         if (c >= 2) begin
            check("stall_qa_hold", qa, sqa);
            check("stall_qb_hold", qb, sqb);
         end
      end
      check("stall_accepts", acc, 2);
      check("stall_in_ready_low", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_first_result", qa ^ qb, 8'h05);
      in_valid = 1'b0; out_ready = 1'b1;
      #1 check("release_in_ready", in_ready, 1);
      @(posedge g_clk); #1;
      check("drain_valid", out_valid, 1);
      check("drain_second_result", qa ^ qb, 8'hAF);
      @(posedge g_clk); #1;
      check("drain_empty", out_valid, 0);
      check("drain_in_ready", in_ready, 1);

      // Asynchronous reset with both stages full
      out_ready = 1'b0;
      drive(vecs[0]); in_valid = 1'b1;
      @(posedge g_clk); #1 drive(vecs[2]);
      @(posedge g_clk); #1 in_valid = 1'b0;
      check("prerst_full", out_valid, 1);
      #2 g_rst = 1'b1;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_qa", qa, 0);
      check("async_rst_qb", qb, 0);
      #1 g_rst = 1'b0;
      @(posedge g_clk); #1;
      check("postrst_no_stale", out_valid, 0);
      check("postrst_in_ready", in_ready, 1);
      out_ready = 1'b1;
      drive(vecs[0]); in_valid = 1'b1;
      @(posedge g_clk); #1 in_valid = 1'b0;
      @(posedge g_clk); #1;
      check("postrst_valid", out_valid, 1);
      check("postrst_and", qa ^ qb, 8'h05);
      @(posedge g_clk); #1;
      check("postrst_single", out_valid, 0);

      // Randomised traffic against the reference model
      sent = 0;
      for (int cyc = 0; cyc < 60000 && !(sent == NR && expq.size() == 0); cyc++) begin
         out_ready = (sent >= NR) || ($urandom_range(0, 3) != 0);
         if (sent < NR && $urandom_range(0, 3) != 0) begin
            op = 2'($urandom_range(0, 3));
            ax = N'($urandom); bx = N'($urandom);
            ay = N'($urandom); by = N'($urandom);
            z  = N'($urandom);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (in_valid && in_ready) begin
            expq.push_back(model(op, ax ^ bx, ay ^ by));
            sent++;
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) check("rnd_unexpected_output", out_valid, 0);
            else check("rnd_result", qa ^ qb, expq.pop_front());
         end
         @(posedge g_clk); #1;
      end
      in_valid = 1'b0;
      check("rnd_all_sent", sent, NR);
      check("rnd_none_lost", expq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
